// File: rtl/dcache_data_array_pkg.sv
// D-cache data array shared types.
// Refill FSM states and default geometry.
package dcache_data_array_pkg;

  localparam int DEF_WAYS    = 2;
  localparam int DEF_WORDS   = 4;
  localparam int DEF_WORD_W  = 32;
  localparam int DEF_INDEX_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/dcache_data_bank.sv
// One way of the D-cache data array.
// Byte-enabled line write, write-first read.
module dcache_data_bank #(
  parameter int INDEX_W = 8,
  parameter int LINE_W  = 128
) (
  input  logic                clk,
  input  logic [LINE_W/8-1:0] we,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [LINE_W-1:0]   wr_data,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic [LINE_W-1:0]   rd_line
);

  localparam int NB    = LINE_W / 8;
  localparam int DEPTH = 1 << INDEX_W;

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) begin
        mem[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Bytes written this cycle bypass the array
  always_comb begin
    rd_line = mem[rd_index];
    if (wr_index == rd_index) begin
      for (int b = 0; b < NB; b++) begin
        if (we[b]) begin
          rd_line[b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_data_array.sv
// D-cache data array: ways of banks, store port,
// critical-word-first refill engine, registered read.
module dcache_data_array
  import dcache_data_array_pkg::*;
#(
  parameter int WAYS    = DEF_WAYS,
  parameter int WORDS   = DEF_WORDS,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int INDEX_W = DEF_INDEX_W,
  localparam int OFF_W  = $clog2(WORDS),
  localparam int BE_W   = WORD_W / 8,
  localparam int LINE_W = WORDS * WORD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [INDEX_W-1:0]     rd_index,
  output logic [WAYS*LINE_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   st_en,
  input  logic [WAYS-1:0]        st_way,
  input  logic [INDEX_W-1:0]     st_index,
  input  logic [OFF_W-1:0]       st_offset,
  input  logic [BE_W-1:0]        st_be,
  input  logic [WORD_W-1:0]      st_data,
  output logic                   st_ready,
  input  logic                   fill_start,
  input  logic [WAYS-1:0]        fill_way,
  input  logic [INDEX_W-1:0]     fill_index,
  input  logic [OFF_W-1:0]       fill_offset,
  input  logic                   fill_valid,
  input  logic [WORD_W-1:0]      fill_data,
  output logic                   fill_busy,
  output logic                   fill_done
);

  localparam int LB = LINE_W / 8;

  fill_state_e          state_q;
  fill_state_e          state_d;
  logic [WAYS-1:0]      fway_q;
  logic [INDEX_W-1:0]   findex_q;
  logic [OFF_W-1:0]     fptr_q;
  logic [OFF_W-1:0]     fcnt_q;
  logic                 beat;
  logic                 st_go;
  logic                 last_beat;

  assign fill_busy = (state_q == S_FILL);
  assign fill_done = (state_q == S_DONE);
  assign st_ready  = !fill_busy;
  assign st_go     = st_en && st_ready;
  assign beat      = fill_busy && fill_valid;
  assign last_beat = (fcnt_q == OFF_W'(WORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (fill_start) state_d = S_FILL;
      S_FILL:  if (beat && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fway_q   <= '0;
      findex_q <= '0;
      fptr_q   <= '0;
      fcnt_q   <= '0;
    end else if (state_q == S_IDLE && fill_start) begin
      fway_q   <= fill_way;
      findex_q <= fill_index;
      fptr_q   <= fill_offset;
      fcnt_q   <= '0;
    end else if (beat) begin
      fptr_q   <= fptr_q + 1'b1;
      fcnt_q   <= fcnt_q + 1'b1;
    end
  end

  logic [INDEX_W-1:0] wr_index;
  logic [WAYS-1:0]    wr_way;
  logic [BE_W-1:0]    wr_be;
  logic [OFF_W-1:0]   wr_off;
  logic [WORD_W-1:0]  wr_word;
  logic [LB-1:0]      line_be;
  logic [LINE_W-1:0]  wr_line;

  // Fill beats and accepted stores never coincide
  always_comb begin
    wr_index = st_index;
    wr_way   = '0;
    wr_be    = '0;
    wr_off   = st_offset;
    wr_word  = st_data;
    unique case (1'b1)
      beat: begin
        wr_index = findex_q;
        wr_way   = fway_q;
        wr_be    = '1;
        wr_off   = fptr_q;
        wr_word  = fill_data;
      end
      st_go: begin
        wr_way = st_way;
        wr_be  = st_be;
      end
      default: ;
    endcase
    line_be = '0;
    line_be[wr_off*BE_W +: BE_W] = wr_be;
    wr_line = {WORDS{wr_word}};
  end

  logic [WAYS*LINE_W-1:0] rd_all;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [LB-1:0] we;
    assign we = wr_way[w] ? line_be : '0;
    dcache_data_bank #(
      .INDEX_W (INDEX_W),
      .LINE_W  (LINE_W)
    ) u_bank (
      .clk      (clk),
      .we       (we),
      .wr_index (wr_index),
      .wr_data  (wr_line),
      .rd_index (rd_index),
      .rd_line  (rd_all[w*LINE_W +: LINE_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_all;
    end
  end

endmodule
